// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the core memory stage and the
// data-memory port. Accepts one request at a time, drives the port from
// latched request fields while in ACCESS, and returns a registered response
// carrying load data or an error code.
//
// Handshake rule for both core-side channels: a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer that raises valid
// holds its payload stable until that edge; ready may change freely. The LSU
// raises req_ready only in IDLE and resp_valid only in RESP, and it holds
// resp_rdata/resp_err constant while resp_valid is high.
module dmem_lsu #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  // core request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // core response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  // data-memory port
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] writeData,
  output logic        memRead,
  output logic        memWrite,
  output logic [1:0]  maskMode,
  output logic        sext,
  input  logic [31:0] readData,
  input  logic        good,
  // FSM state for observation: 0 IDLE, 1 ACCESS, 2 RESP
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_next;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic        dec_illegal;
  logic        dec_misaligned;
  logic        accept;
  logic        timed_out;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign cnt_next  = cnt_q + 8'd1;
  // The access that completes this cycle is the TIMEOUT-th one.
  assign timed_out = (cnt_next >= TMO);

  // Decode the incoming request; illegal funct3 outranks misalignment.
  always_comb begin
    dec_illegal    = 1'b0;
    dec_misaligned = 1'b0;
    if (req_we) begin
      dec_illegal = (req_funct3 > 3'd2);
    end else begin
      dec_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                    (req_funct3 == 3'd7);
    end
    dec_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; good beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (dec_illegal || dec_misaligned) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (good || timed_out) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the request fields at acceptance; they feed the port in ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Access-cycle counter: cleared on entry to ACCESS, counts while there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (accept) begin
      cnt_q <= 8'd0;
    end else if (state_q == S_ACCESS) begin
      cnt_q <= cnt_next;
    end
  end

  // Response registers: written once per request, then held through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
      err_q   <= ERR_OK;
    end else if (accept) begin
      if (dec_illegal) begin
        rdata_q <= 32'd0;
        err_q   <= ERR_ILLEGAL;
      end else if (dec_misaligned) begin
        rdata_q <= 32'd0;
        err_q   <= ERR_MISALIGN;
      end
    end else if (state_q == S_ACCESS) begin
      if (good) begin
        rdata_q <= we_q ? 32'd0 : readData;
        err_q   <= ERR_OK;
      end else if (timed_out) begin
        rdata_q <= 32'd0;
        err_q   <= ERR_TIMEOUT;
      end
    end
  end

  // Outputs: the port is live only in ACCESS, so a store commits once.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    valid      = 1'b0;
    addr       = 32'd0;
    writeData  = 32'd0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    maskMode   = 2'b00;
    sext       = 1'b0;
    dbg_state  = state_q;
    if (state_q == S_ACCESS) begin
      valid     = 1'b1;
      addr      = addr_q;
      writeData = wdata_q;
      memRead   = ~we_q;
      memWrite  = we_q;
      maskMode  = funct3_q[1:0];
      sext      = ~we_q & ~funct3_q[2];
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu with a small byte-addressed port model.
module tb_dmem_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  maskMode;
  logic        sext;
  logic [31:0] readData;
  logic        good;
  logic [1:0]  dbg_state;

  logic        good_en;
  logic [7:0]  mem [0:255];

  int n_tests;
  int n_fail;

  logic [31:0] r_data;
  logic [1:0]  r_err;
  int          lat;
  int          vcnt;
  int          wcnt;

  dmem_lsu #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .valid(valid), .addr(addr), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .maskMode(maskMode),
    .sext(sext), .readData(readData), .good(good), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port model: acknowledges immediately when enabled.
  assign good = valid && good_en;

  always @(posedge clk) begin
    if (valid && good && memWrite) begin
      mem[addr[7:0]] <= writeData[7:0];
      if (maskMode != 2'b00) mem[8'(addr[7:0] + 8'd1)] <= writeData[15:8];
      if (maskMode == 2'b10) begin
        mem[8'(addr[7:0] + 8'd2)] <= writeData[23:16];
        mem[8'(addr[7:0] + 8'd3)] <= writeData[31:24];
      end
    end
  end

  always_comb begin
    readData = 32'd0;
    case (maskMode)
      2'b00: readData = {{24{sext & mem[addr[7:0]][7]}}, mem[addr[7:0]]};
      2'b01: readData = {{16{sext & mem[8'(addr[7:0] + 8'd1)][7]}},
                         mem[8'(addr[7:0] + 8'd1)], mem[addr[7:0]]};
      default: readData = {mem[8'(addr[7:0] + 8'd3)], mem[8'(addr[7:0] + 8'd2)],
                           mem[8'(addr[7:0] + 8'd1)], mem[addr[7:0]]};
    endcase
  end

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: issue one request and wait (bounded) for the response.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat  = 1;
    vcnt = 0;
    wcnt = 0;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      vcnt += int'(valid);
      wcnt += int'(memWrite);
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("resp_arrives", 32'(lat < 100), 32'd1);
    r_data = resp_rdata;
    r_err  = resp_err;
  endtask

  // Driver: accept the pending response.
  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("release_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; good_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_port", {valid, memRead, memWrite, sext, maskMode}, 32'd0);
    check_eq("rst_addr_wd", addr | writeData, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // sw then lw
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check_eq("sw_err", 32'(r_err), 32'd0);
    check_eq("sw_rdata", r_data, 32'd0);
    check_eq("sw_latency", 32'(lat), 32'd2);
    check_eq("sw_wr_cycles", 32'(wcnt), 32'd1);
    release_resp();
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    check_eq("lw_rdata", r_data, 32'hDEADBEEF);
    check_eq("lw_err", 32'(r_err), 32'd0);
    check_eq("lw_latency", 32'(lat), 32'd2);
    check_eq("lw_wr_cycles", 32'(wcnt), 32'd0);

    // Backpressure: response held stable, no new request accepted.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      check_eq("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check_eq("bp_err", 32'(resp_err), 32'd0);
      check_eq("bp_ready", {31'd0, req_ready}, 32'd0);
      check_eq("bp_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = 1'b0;
    release_resp();

    // Sign extension
    do_req(1'b1, 3'b000, 32'h21, 32'h00000080);
    check_eq("sb_wr_cycles", 32'(wcnt), 32'd1);
    release_resp();
    do_req(1'b0, 3'b000, 32'h21, 32'd0);
    check_eq("lb_rdata", r_data, 32'hFFFFFF80);
    release_resp();
    do_req(1'b0, 3'b100, 32'h21, 32'd0);
    check_eq("lbu_rdata", r_data, 32'h00000080);
    release_resp();
    do_req(1'b0, 3'b001, 32'h20, 32'd0);
    check_eq("lh_rdata", r_data, 32'hFFFF8000);
    release_resp();
    do_req(1'b0, 3'b101, 32'h20, 32'd0);
    check_eq("lhu_rdata", r_data, 32'h00008000);
    release_resp();

    // Misaligned
    do_req(1'b0, 3'b010, 32'h12, 32'd0);
    check_eq("mis_lw_err", 32'(r_err), 32'd1);
    check_eq("mis_lw_latency", 32'(lat), 32'd1);
    check_eq("mis_lw_valid", 32'(vcnt), 32'd0);
    release_resp();
    do_req(1'b1, 3'b001, 32'h13, 32'h00001234);
    check_eq("mis_sh_err", 32'(r_err), 32'd1);
    check_eq("mis_sh_valid", 32'(vcnt), 32'd0);
    release_resp();
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    check_eq("mis_sh_mem", r_data, 32'hDEADBEEF);
    release_resp();

    // Illegal funct3 (and priority over misalignment)
    do_req(1'b0, 3'b011, 32'h10, 32'd0);
    check_eq("ill_ld_err", 32'(r_err), 32'd2);
    check_eq("ill_ld_latency", 32'(lat), 32'd1);
    check_eq("ill_ld_valid", 32'(vcnt), 32'd0);
    release_resp();
    do_req(1'b1, 3'b100, 32'h10, 32'h11111111);
    check_eq("ill_st_err", 32'(r_err), 32'd2);
    check_eq("ill_st_valid", 32'(vcnt), 32'd0);
    release_resp();
    do_req(1'b1, 3'b110, 32'h13, 32'h11111111);
    check_eq("ill_prio_err", 32'(r_err), 32'd2);
    release_resp();

    // Timeout
    good_en = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    check_eq("tmo_err", 32'(r_err), 32'd3);
    check_eq("tmo_rdata", r_data, 32'd0);
    check_eq("tmo_access_cycles", 32'(vcnt), 32'd15);
    check_eq("tmo_port_drop", {valid, memRead, memWrite, sext, maskMode}, 32'd0);
    release_resp();

    // Reset during ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rip_in_access", 32'(valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rip_state", 32'(dbg_state), 32'd0);
    check_eq("rip_req_ready", 32'(req_ready), 32'd1);
    check_eq("rip_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rip_port", {valid, memRead, memWrite, sext, maskMode}, 32'd0);
    check_eq("rip_rdata_err", resp_rdata | 32'(resp_err), 32'd0);
    good_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
